if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the rv32i core; directly upstream of Decoder, whose .inst input it drives.

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 tb/tb_if_fetch_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: RV32 opcode, boot constants, fetch FSM encoding.
// Pure declarations, no logic.
package if_fetch_stage_pkg;

  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [31:0] RV_NOP_INST = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STALL = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst,pc} holding register that parks a fetched word while decode stalls.
// Zero latency: the value loaded on one edge is visible after it; clear overrides load.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_full,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic        r_full;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_inst <= '0;
      r_pc   <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// rv32i instruction fetch: one outstanding imem read, 2-cycle req-to-if_valid latency.
// Decode backpressure parks one word in the skid buffer; fetching then halts until id_ready.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV_RESET_PC,
  parameter logic [31:0] NOP_INST = RV_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  fetch_state_e r_state;
  logic         r_kill;
  logic         r_if_valid;
  logic [31:0]  r_pc;
  logic [31:0]  r_if_inst;
  logic [31:0]  r_if_pc;

  logic         w_req_fire;
  logic         w_rsp_fire;
  logic         w_xfer;
  logic         w_slot_free;
  logic         w_skid_load;
  logic         w_skid_unload;
  logic         w_skid_full;
  logic [31:0]  w_skid_inst;
  logic [31:0]  w_skid_pc;

  assign w_req_fire    = (r_state == ST_REQ) && imem_req_ready;
  assign w_rsp_fire    = (r_state == ST_WAIT) && imem_rsp_valid;
  assign w_xfer        = r_if_valid && id_ready;
  assign w_slot_free   = !r_if_valid || id_ready;
  assign w_skid_load   = w_rsp_fire && !r_kill && !redirect_valid && !w_slot_free;
  assign w_skid_unload = (r_state == ST_STALL) && id_ready && w_skid_full && !redirect_valid;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (redirect_valid),
    .i_inst   (imem_rsp_data),
    .i_pc     (r_pc),
    .o_full   (w_skid_full),
    .o_inst   (w_skid_inst),
    .o_pc     (w_skid_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
      r_if_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc       <= word_align(redirect_pc);
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
      // A request already accepted by imem must have its response swallowed.
      if (w_rsp_fire) begin
        r_state <= ST_REQ;
        r_kill  <= 1'b0;
      end else if ((r_state == ST_WAIT) || w_req_fire) begin
        r_state <= ST_WAIT;
        r_kill  <= 1'b1;
      end else begin
        r_state <= ST_REQ;
        r_kill  <= 1'b0;
      end
    end else begin
      if (w_xfer) begin
        r_if_valid <= 1'b0;
        r_if_inst  <= NOP_INST;
      end
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
          if (imem_req_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= ST_REQ;
            end else begin
              r_pc <= r_pc + 32'd4;
              if (w_slot_free) begin
                r_if_valid <= 1'b1;
                r_if_inst  <= imem_rsp_data;
                r_if_pc    <= r_pc;
                r_state    <= ST_REQ;
              end else begin
                r_state <= ST_STALL;
              end
            end
          end
        end
        ST_STALL: begin
          if (id_ready && w_skid_full) begin
            r_if_valid <= 1'b1;
            r_if_inst  <= w_skid_inst;
            r_if_pc    <= w_skid_pc;
            r_state    <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_inst        = r_if_inst;
  assign if_pc          = r_if_pc;
  assign if_pc_plus4    = r_if_pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: behavioural imem, expected-PC-stream model, directed and random phases.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
  } redir_vec_t;

  redir_vec_t  vecs [5];
  int          checks, errors, cyc, n_req, n_xfer, mem_cnt, mem_lat;
  int          last_req_cyc, last_xfer_cyc, rel, req0, base;
  logic        mem_busy, rand_lat, stale_rsp;
  logic [31:0] mem_addr, exp_pc;
  logic        p_req_hold, p_out_hold;
  logic [31:0] p_req_addr, p_inst, p_pc, p_pc4;
  logic        last_req_fire, last_xfer;
  logic [31:0] last_req_addr, last_xfer_pc, last_xfer_pc4, last_xfer_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory answers one accepted request after its latency.
  task automatic setup();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (stale_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (reset && mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic eval();
    last_req_fire = 1'b0;
    last_xfer     = 1'b0;
    if (!reset) begin
      mem_busy   = 1'b0;
      exp_pc     = RESET_PC;
      p_req_hold = 1'b0;
      p_out_hold = 1'b0;
      return;
    end
    if (imem_req_valid) begin
      chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
      chk("req_align", imem_req_addr & 32'd3, 32'd0);
    end
    if (p_req_hold) begin
      chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("req_hold_addr", imem_req_addr, p_req_addr);
    end
    if (p_out_hold) begin
      chk("out_hold_valid", {31'd0, if_valid}, 32'd1);
      chk("out_hold_inst", if_inst, p_inst);
      chk("out_hold_pc", if_pc, p_pc);
      chk("out_hold_pc4", if_pc_plus4, p_pc4);
    end
    if (!if_valid) chk("idle_inst_nop", if_inst, NOP);
    if (if_valid && id_ready) begin
      last_xfer      = 1'b1;
      last_xfer_pc   = if_pc;
      last_xfer_pc4  = if_pc_plus4;
      last_xfer_inst = if_inst;
      last_xfer_cyc  = cyc;
      n_xfer++;
      chk("xfer_pc", if_pc, exp_pc);
      chk("xfer_inst", if_inst, mem_word(exp_pc));
      chk("xfer_pc4", if_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_rsp_valid) mem_busy = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      last_req_fire = 1'b1;
      last_req_addr = imem_req_addr;
      last_req_cyc  = cyc;
      n_req++;
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = (rand_lat ? int'($urandom_range(1, 3)) : mem_lat) - 1;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
    p_req_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
    p_req_addr = imem_req_addr;
    p_out_hold = if_valid && !id_ready && !redirect_valid;
    p_inst     = if_inst;
    p_pc       = if_pc;
    p_pc4      = if_pc_plus4;
  endtask

  task automatic cycle();
    setup();
    #4;
    eval();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (last_req_fire) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no imem request within 60 cycles", name);
  endtask

  task automatic wait_xfer(input string name);
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (last_xfer) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no transfer to decode within 60 cycles", name);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_pc    = tgt;
    redirect_valid = 1'b1;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};
    vecs[4] = '{32'h0000_0005, 32'h0000_0004, 32'h0000_0008};

    checks = 0; errors = 0; cyc = 0; n_req = 0; n_xfer = 0;
    mem_busy = 0; mem_cnt = 0; mem_lat = 1; rand_lat = 0; stale_rsp = 0;
    mem_addr = 0; exp_pc = RESET_PC; p_req_hold = 0; p_out_hold = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // T1: reset values, then boot fetch from RESET_PC
    repeat (3) cycle();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_if_pc4", if_pc_plus4, RESET_PC + 32'd4);

    reset = 1'b1; id_ready = 1'b1; imem_req_ready = 1'b1;
    rel = cyc;
    wait_req("boot_req");
    chk("boot_req_addr", last_req_addr, RESET_PC);
    chk("boot_req_cycle", last_req_cyc - rel, 32'd1);
    req0 = last_req_cyc;
    wait_xfer("boot_xfer");
    chk("boot_inst", last_xfer_inst, 32'h0000_0013);
    chk("boot_pc", last_xfer_pc, 32'h0);
    chk("boot_pc4", last_xfer_pc4, 32'h4);
    chk("boot_latency", last_xfer_cyc - req0, 32'd2);

    // T2: streaming at one instruction every two cycles
    for (int i = 1; i < 4; i++) begin
      wait_xfer("stream_xfer");
      chk("stream_pc", last_xfer_pc, RESET_PC + 32'(4 * i));
      chk("stream_inst", last_xfer_inst, mem_word(RESET_PC + 32'(4 * i)));
      chk("stream_cycle", last_xfer_cyc - req0, 32'(2 + 2 * i));
    end

    // T3: decode stall holds outputs, parks one word, stops fetching
    id_ready = 1'b0;
    redirect_to(32'h200);
    for (int k = 0; k < 30 && !if_valid; k++) cycle();
    chk("stall_first_valid", {31'd0, if_valid}, 32'd1);
    base = n_req;
    repeat (6) cycle();
    chk("stall_req_count", n_req - base, 32'd1);
    chk("stall_hold_pc", if_pc, 32'h200);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_xfer("stall_drain");
      chk("stall_drain_pc", last_xfer_pc, 32'h200 + 32'(4 * i));
    end

    // T4: redirect while the fetch of 0x8 is outstanding (lat 1 collides with the response)
    for (int lat = 1; lat <= 3; lat++) begin
      mem_lat = lat;
      redirect_to(32'h0);
      for (int k = 0; k < 60; k++) begin
        cycle();
        if (last_req_fire && last_req_addr == 32'h8) break;
      end
      chk("kill_setup_addr", last_req_addr, 32'h8);
      redirect_to(32'h100);
      wait_req("kill_req");
      chk("kill_req_addr", last_req_addr, 32'h100);
      wait_req("kill_req2");
      chk("kill_xfer_pc", last_xfer ? last_xfer_pc : 32'hFFFF_FFFF, 32'h100);
    end

    // T5: redirect alignment and PC wrap, table driven
    mem_lat = 1;
    foreach (vecs[i]) begin
      redirect_to(vecs[i].tgt);
      wait_req("edge_req");
      chk("edge_req_addr", last_req_addr, vecs[i].exp_pc);
      wait_req("edge_req2");
      chk("edge_req2_addr", last_req_addr, vecs[i].exp_pc4);
      chk("edge_xfer_pc", last_xfer ? last_xfer_pc : 32'hFFFF_FFFF, vecs[i].exp_pc);
      chk("edge_xfer_pc4", last_xfer_pc4, vecs[i].exp_pc4);
    end

    // Random traffic against the sequential-stream model
    rand_lat = 1'b1;
    base = n_xfer;
    for (int n = 0; n < 3000; n++) begin
      id_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", {31'd0, (n_xfer - base) > 100}, 32'd1);

    // T6: reset during WAIT, stale response in the release cycle
    rand_lat = 1'b0; mem_lat = 3; id_ready = 1'b1; imem_req_ready = 1'b1;
    redirect_to(32'h40);
    wait_req("mid_req");
    reset = 1'b0;
    cycle();
    cycle();
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    reset = 1'b1;
    stale_rsp = 1'b1;
    cycle();
    stale_rsp = 1'b0;
    chk("stale_if_valid", {31'd0, if_valid}, 32'd0);
    mem_lat = 1;
    wait_req("refetch_req");
    chk("refetch_addr", last_req_addr, RESET_PC);
    wait_req("refetch_req2");
    chk("refetch_pc", last_xfer ? last_xfer_pc : 32'hFFFF_FFFF, RESET_PC);
    chk("refetch_inst", last_xfer_inst, 32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
